// File: rtl/alu_seq_unit.sv
// EX-stage ALU: decodes alu_op/funct, runs single-cycle ops with a registered result
// and iterates unsigned MULTU/DIVU over WIDTH cycles into internal HI/LO registers.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: an op is taken when in_valid=1 and busy=0 at a rising edge; while
  // busy=1 inputs are ignored and upstream must hold the instruction.

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] ALU_OP_NOP    = 3'd0;
  localparam logic [2:0] ALU_OP_ADD    = 3'd1;
  localparam logic [2:0] ALU_OP_SUB    = 3'd2;
  localparam logic [2:0] ALU_OP_AND    = 3'd3;
  localparam logic [2:0] ALU_OP_OR     = 3'd4;
  localparam logic [2:0] ALU_OP_R_TYPE = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_e;

  typedef enum logic [3:0] {
    K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_SLTU,
    K_MULTU, K_DIVU, K_MFHI, K_MFLO, K_ILL
  } kind_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             rv_q, rv_d;
  logic             ov_q, ov_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;

  kind_e            kind;
  logic [WIDTH-1:0] sum, diff, res;
  logic             wr_res;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    kind = K_ILL;
    case (alu_op)
      ALU_OP_NOP: kind = K_NOP;
      ALU_OP_ADD: kind = K_ADD;
      ALU_OP_SUB: kind = K_SUB;
      ALU_OP_AND: kind = K_AND;
      ALU_OP_OR:  kind = K_OR;
      ALU_OP_R_TYPE: begin
        case (funct)
          6'h20:   kind = K_ADD;
          6'h22:   kind = K_SUB;
          6'h24:   kind = K_AND;
          6'h25:   kind = K_OR;
          6'h27:   kind = K_NOR;
          6'h2A:   kind = K_SLT;
          6'h2B:   kind = K_SLTU;
          6'h19:   kind = K_MULTU;
          6'h1B:   kind = K_DIVU;
          6'h10:   kind = K_MFHI;
          6'h12:   kind = K_MFLO;
          default: kind = K_ILL;
        endcase
      end
      default: kind = K_ILL;
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  // One LSB-first shift-add step: opnd_q is the multiplicand, lo_q the remaining multiplier.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  // One restoring-division step: opnd_q is the divisor, bit WIDTH of div_diff is the sign.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    zero_d   = zero_q;
    rv_d     = 1'b0;
    ov_d     = 1'b0;
    dbz_d    = 1'b0;
    ill_d    = 1'b0;
    res      = '0;
    wr_res   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (kind)
            K_ADD: begin
              res    = sum;
              wr_res = 1'b1;
              ov_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            K_SUB: begin
              res    = diff;
              wr_res = 1'b1;
              ov_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            K_AND:  begin res = a & b;    wr_res = 1'b1; end
            K_OR:   begin res = a | b;    wr_res = 1'b1; end
            K_NOR:  begin res = ~(a | b); wr_res = 1'b1; end
            K_SLT:  begin res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))}; wr_res = 1'b1; end
            K_SLTU: begin res = {{(WIDTH-1){1'b0}}, (a < b)}; wr_res = 1'b1; end
            K_MFHI: begin res = hi_q; wr_res = 1'b1; end
            K_MFLO: begin res = lo_q; wr_res = 1'b1; end
            K_MULTU: begin
              opnd_d  = a;
              lo_d    = b;
              hi_d    = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_MUL;
            end
            K_DIVU: begin
              if (b == '0) begin
                hi_d  = a;
                lo_d  = '1;
                dbz_d = 1'b1;
              end else begin
                opnd_d  = b;
                lo_d    = a;
                hi_d    = '0;
                cnt_d   = CW'(WIDTH);
                state_d = S_DIV;
              end
            end
            K_ILL:   ill_d = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_res) begin
      result_d = res;
      zero_d   = (res == '0);
      rv_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      rv_q     <= 1'b0;
      ov_q     <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      rv_q     <= rv_d;
      ov_q     <= ov_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign zero         = zero_q;
  assign overflow     = ov_q;
  assign div_by_zero  = dbz_q;
  assign illegal      = ill_q;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: a WIDTH=32 and a WIDTH=8 instance share stimulus;
// each phase resets both and checks only the instance under test.
module tb_alu_seq_unit;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_R   = 3'd7;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B, F_MULTU = 6'h19, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [31:0] result32;
  logic        rv32, zero32, ov32, dbz32, ill32, busy32;
  logic [1:0]  dbg32;
  logic [7:0]  result8;
  logic        rv8, zero8, ov8, dbz8, ill8, busy8;
  logic [1:0]  dbg8;

  int checks = 0;
  int failures = 0;
  int n;

  alu_seq_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .result(result32), .result_valid(rv32), .zero(zero32),
    .overflow(ov32), .div_by_zero(dbz32), .illegal(ill32), .busy(busy32),
    .dbg_state(dbg32)
  );

  alu_seq_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .a(a[7:0]), .b(b[7:0]), .result(result8), .result_valid(rv8), .zero(zero8),
    .overflow(ov8), .div_by_zero(dbz8), .illegal(ill8), .busy(busy8),
    .dbg_state(dbg8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    a        = av;
    b        = bv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
  endtask

  // Counts busy cycles starting at the current (first post-accept) cycle, bounded.
  task automatic count_busy(input bit w8, input int start, output int cnt);
    cnt = start;
    while ((w8 ? busy8 : busy32) && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    do_reset();
    chk("rst_result", result32, 32'h0);
    chk("rst_zero", {31'h0, zero32}, 32'h1);
    chk("rst_pulses", {28'h0, rv32, ov32, dbz32, ill32}, 32'h0);
    chk("rst_busy", {31'h0, busy32}, 32'h0);

    issue(OP_R, F_ADD, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_result", result32, 32'h8000_0000);
    chk("add_ovf_rv", {31'h0, rv32}, 32'h1);
    chk("add_ovf_ov", {31'h0, ov32}, 32'h1);
    chk("add_ovf_zero", {31'h0, zero32}, 32'h0);
    tick();
    chk("pulse_end_rv", {31'h0, rv32}, 32'h0);
    chk("pulse_end_ov", {31'h0, ov32}, 32'h0);

    issue(OP_R, F_SUB, 32'd5, 32'd5);
    chk("sub_result", result32, 32'h0);
    chk("sub_zero", {31'h0, zero32}, 32'h1);
    chk("sub_ov", {31'h0, ov32}, 32'h0);

    issue(OP_R, F_SLT, 32'hFFFF_FFFF, 32'h1);
    chk("slt", result32, 32'h1);
    issue(OP_R, F_SLTU, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", result32, 32'h0);
    issue(OP_R, F_NOR, 32'h0, 32'hFFFF_0000);
    chk("nor", result32, 32'h0000_FFFF);
    issue(OP_SUB, 6'h0, 32'h8000_0000, 32'h1);
    chk("isub_ovf_result", result32, 32'h7FFF_FFFF);
    chk("isub_ovf_ov", {31'h0, ov32}, 32'h1);
    issue(OP_ADD, 6'h0, 32'd2, 32'd3);
    chk("b2b_add", result32, 32'd5);
    issue(OP_AND, 6'h0, 32'hF0F0, 32'hFF00);
    chk("b2b_and", result32, 32'hF000);
    chk("b2b_and_rv", {31'h0, rv32}, 32'h1);
    issue(OP_OR, 6'h0, 32'hF0, 32'h0F);
    chk("or", result32, 32'hFF);
    issue(OP_NOP, 6'h0, 32'h1, 32'h1);
    chk("nop_pulses", {28'h0, rv32, ov32, dbz32, ill32}, 32'h0);
    chk("nop_result", result32, 32'hFF);

    // MULTU with ops presented (and ignored) during the first busy cycles
    issue(OP_R, F_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("mul_busy", {31'h0, busy32}, 32'h1);
    chk("mul_rv", {31'h0, rv32}, 32'h0);
    chk("mul_state", {30'h0, dbg32}, 32'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      alu_op   = OP_R;
      funct    = F_ADD;
      a        = 32'd1;
      b        = 32'd1;
      n++;
      tick();
      chk("mul_ignore_rv", {31'h0, rv32}, 32'h0);
      chk("mul_ignore_result", result32, 32'hFF);
    end
    in_valid = 1'b0;
    count_busy(1'b0, n, n);
    chk("mul_busy_len", n, 32'd32);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("mul_mfhi", result32, 32'h1);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("mul_mflo", result32, 32'hFFFF_FFFE);

    issue(OP_R, F_DIVU, 32'd100, 32'd7);
    chk("div_state", {30'h0, dbg32}, 32'h2);
    count_busy(1'b0, 0, n);
    chk("div_busy_len", n, 32'd32);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("div_mflo", result32, 32'd14);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("div_mfhi", result32, 32'd2);

    issue(OP_R, F_DIVU, 32'h1234, 32'h0);
    chk("dz_pulse", {31'h0, dbz32}, 32'h1);
    chk("dz_busy", {31'h0, busy32}, 32'h0);
    chk("dz_rv", {31'h0, rv32}, 32'h0);
    chk("dz_result_held", result32, 32'd2);
    tick();
    chk("dz_pulse_end", {31'h0, dbz32}, 32'h0);
    chk("dz_busy_after", {31'h0, busy32}, 32'h0);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("dz_mfhi", result32, 32'h1234);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("dz_mflo", result32, 32'hFFFF_FFFF);

    issue(OP_R, 6'h3F, 32'h5, 32'h5);
    chk("ill_funct", {31'h0, ill32}, 32'h1);
    chk("ill_funct_rv", {31'h0, rv32}, 32'h0);
    chk("ill_funct_result", result32, 32'hFFFF_FFFF);
    issue(3'd5, 6'h0, 32'h5, 32'h5);
    chk("ill_op", {31'h0, ill32}, 32'h1);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("ill_lo_kept", result32, 32'hFFFF_FFFF);

    // Reset at iteration 10 of a MULTU
    issue(OP_R, F_MULTU, 32'd3, 32'd5);
    repeat (9) tick();
    chk("abort_busy_before", {31'h0, busy32}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'h0, busy32}, 32'h0);
    chk("abort_result", result32, 32'h0);
    chk("abort_zero", {31'h0, zero32}, 32'h1);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("abort_mflo", result32, 32'h0);
    chk("abort_mflo_rv", {31'h0, rv32}, 32'h1);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("abort_mfhi", result32, 32'h0);

    issue(OP_R, F_ADD, 32'd7, 32'd8);
    chk("pre_rst_add", result32, 32'd15);
    reset    = 1'b1;
    in_valid = 1'b1;
    alu_op   = OP_R;
    funct    = F_ADD;
    a        = 32'd1;
    b        = 32'd1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_wins_rv", {31'h0, rv32}, 32'h0);
    chk("rst_wins_result", result32, 32'h0);

    // WIDTH=8 instance
    do_reset();
    chk("w8_rst_result", {24'h0, result8}, 32'h0);
    chk("w8_rst_zero", {31'h0, zero8}, 32'h1);
    chk("w8_rst_pulses", {28'h0, rv8, ov8, dbz8, ill8}, 32'h0);
    issue(OP_R, F_MULTU, 32'hFF, 32'h2);
    chk("w8_mul_state", {30'h0, dbg8}, 32'h1);
    count_busy(1'b1, 0, n);
    chk("w8_mul_busy_len", n, 32'd8);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("w8_mul_mfhi", {24'h0, result8}, 32'h01);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("w8_mul_mflo", {24'h0, result8}, 32'hFE);
    issue(OP_R, F_DIVU, 32'd100, 32'd7);
    count_busy(1'b1, 0, n);
    chk("w8_div_busy_len", n, 32'd8);
    issue(OP_R, F_MFLO, 32'h0, 32'h0);
    chk("w8_div_mflo", {24'h0, result8}, 32'd14);
    issue(OP_R, F_MFHI, 32'h0, 32'h0);
    chk("w8_div_mfhi", {24'h0, result8}, 32'd2);
    issue(OP_R, F_ADD, 32'h7F, 32'h01);
    chk("w8_add_ovf", {24'h0, result8}, 32'h80);
    chk("w8_add_ov", {31'h0, ov8}, 32'h1);
    issue(OP_R, F_DIVU, 32'h34, 32'h0);
    chk("w8_dz", {31'h0, dbz8}, 32'h1);
    issue(OP_R, 6'h3F, 32'h0, 32'h0);
    chk("w8_ill", {31'h0, ill8}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised successor to the combinational ALU control decode: one block that decodes `alu_op`/`funct` and executes the operation at width `WIDTH`. Single-cycle ops give a registered result one cycle after acceptance. Unsigned multiply and divide iterate over `WIDTH` cycles into internal HI/LO registers. The block sits in the EX stage, and its `busy` output stalls the pipeline while an iterative op runs.

## Interface
- `WIDTH`, 32, datapath width in bits (≥4).
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation presented this cycle.
- `alu_op`  in  3  `ALU_OP_*` code (`Headers/ALUOps.v`).
- `funct`  in  6  MIPS funct field, used only when `alu_op == ALU_OP_R_TYPE`.
- `a`, `b`  in  `WIDTH` each  operands (rs, rt).
- `result`  out  `WIDTH`  registered result.
- `result_valid`  out  1  one-cycle pulse, `result` is to be written back.
- `zero`  out  1  registered, `result == 0`, updated with `result`.
- `overflow`  out  1  one-cycle pulse, signed overflow on ADD/SUB.
- `div_by_zero`  out  1  one-cycle pulse, DIVU with `b == 0`.
- `illegal`  out  1  one-cycle pulse, undefined funct or `alu_op`.
- `busy`  out  1  iterative op in progress, inputs ignored.

## Operation
- Decode (`ALU_OP_R_TYPE` funct codes):
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR.
  - 0x2A SLT (signed), 0x2B SLTU.
  - 0x19 MULTU, 0x1B DIVU.
  - 0x10 MFHI, 0x12 MFLO.
- Decode (non-R-type): `ALU_OP_ADD`/`OR`/`AND`/`SUB` map directly. `ALU_OP_NOP` is accepted with no outputs pulsed.
- Arithmetic is mod 2^`WIDTH`. `overflow` is set when the operand signs imply a signed overflow; the result is still written (wrapped).
- FSM states: IDLE, MUL, DIV. A counter of width clog2(`WIDTH`)+1 tracks iterations.
- IDLE, `in_valid`, single-cycle op:
  - `result`, `zero` and the pulses register at the next edge; state stays IDLE.
- IDLE, `in_valid`, MULTU:
  - Latch `a` and `b`; HI=0; counter=`WIDTH`; go to MUL.
  - Each MUL cycle does one shift-add step on {HI,LO}, LSB first, and decrements the counter.
  - At counter 0, {HI,LO}=`a*b` (unsigned, 2·`WIDTH` bits); return to IDLE.
- IDLE, `in_valid`, DIVU, `b != 0`:
  - Go to DIV and run a `WIDTH`-step restoring division.
  - On completion LO=quotient, HI=remainder; return to IDLE.
- DIVU with `b == 0`: no iteration. HI=`a`, LO=all ones, `div_by_zero` pulses next cycle, state stays IDLE.
- MULTU/DIVU never assert `result_valid`; `result` and `zero` hold their previous values.
- MFHI/MFLO: `result`=HI/LO, `result_valid` pulses.
- Undefined funct or `alu_op`: `illegal` pulses; `result`, HI and LO are unchanged; no `result_valid`.
- `in_valid` while `busy` is ignored entirely. Upstream holds the instruction until `busy` falls.

## Timing
- Reset values: `result`=0, `zero`=1, all pulses 0, `busy`=0, HI=LO=0, state IDLE, counter 0.
- Single-cycle op accepted at edge N: outputs are valid during cycle N+1, and pulses last exactly one cycle.
- MULTU/DIVU accepted at edge N:
  - `busy`=1 from cycle N+1 through cycle N+`WIDTH`.
  - HI/LO hold final values from edge N+`WIDTH`; `busy`=0 in cycle N+`WIDTH`+1.
  - An MFHI presented in cycle N+`WIDTH`+1 returns the new HI in cycle N+`WIDTH`+2.
- Back-to-back single-cycle ops: one accepted per cycle, with no bubble.
- `reset` during MUL/DIV: aborts the op, HI=LO=0, `busy`=0 in the next cycle.
- `reset` and `in_valid` in the same cycle: reset wins and the op is dropped.
- `busy` is driven from the registered state only, never combinationally from `in_valid`.

## Test plan
- Reset then ADD: `a`=0x7FFFFFFF, `b`=1 -> `result`=0x80000000, `result_valid`=1, `overflow`=1, `zero`=0. Then SUB 5-5 -> `result`=0, `zero`=1, `overflow`=0.
- MULTU 0xFFFFFFFF×2, then MFHI and MFLO:
  - `busy` high for exactly 32 cycles.
  - MFHI -> 0x00000001; MFLO -> 0xFFFFFFFE.
- DIVU 100/7, then MFLO and MFHI -> 14 (0xE) and 2; `busy` 32 cycles.
- DIVU 0x1234/0:
  - `div_by_zero` pulses one cycle later with `busy` never asserted.
  - MFHI -> 0x1234; MFLO -> 0xFFFFFFFF.
- Robustness while `busy`:
  - Ops presented during a MULTU are ignored; the result stays unchanged.
  - Funct 0x3F -> `illegal` pulse, no `result_valid`.
  - `reset` at iteration 10 -> `busy`=0 next cycle and MFLO -> 0.
- SLT vs SLTU with `a`=0xFFFFFFFF, `b`=1 -> 1 and 0 respectively. Repeat the MULTU and DIVU cases at `WIDTH`=8 with a `busy` length of 8.
